// File: rtl/uart_receiver.sv
// Purpose: 12-bit-frame serial receiver (start, 8 data LSB first, parity, 2 stops), one bit per clk.
// Latency: start bit sampled at edge E0 -> frame held (dataValid=1) in the cycle after edge E11.
// Backpressure: one held frame; a frame completing while unacknowledged is dropped and overrun set.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   bitIn             serial line, idle high, already synchronous to clk
//   ack               consumer accepts the held frame (ignored while dataValid=0)
//   dataOut           data byte of the held frame
//   dataValid         a frame is held until acknowledged
//   parityError       parity check failed for the held frame
//   frameError        at least one stop bit of the held frame was 0
//   overrun           sticky: a completed frame was discarded; cleared by ack
//   busy              receiver is inside a frame (not in ARM or IDLE)
module uart_receiver #(
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bitIn,
  input  logic       ack,
  output logic [7:0] dataOut,
  output logic       dataValid,
  output logic       parityError,
  output logic       frameError,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_ARM    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;       // data bit position d0..d7
  logic        par_q, par_d;       // running XOR of data and parity bits
  logic [7:0]  shift_q, shift_d;   // frame being assembled
  logic        ferr_q, ferr_d;     // stop1 of the current frame was 0
  logic [7:0]  data_q, data_d;
  logic        dv_q, dv_d;
  logic        perr_q, perr_d;
  logic        fe_q, fe_d;
  logic        ovr_q, ovr_d;
  logic        done;               // STOP2 sampled this cycle: frame completes on this edge

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    par_d   = par_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    data_d  = data_q;
    dv_d    = dv_q;
    perr_d  = perr_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    done    = 1'b0;

    case (state_q)
      // After reset the line may be held low; wait for a 1 so a stuck-low
      // line is not mistaken for a start bit.
      ST_ARM: begin
        if (bitIn) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!bitIn) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
          par_d   = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_DATA: begin
        shift_d[idx_q] = bitIn;
        par_d          = par_q ^ bitIn;
        idx_d          = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = ST_PARITY;
      end
      ST_PARITY: begin
        par_d   = par_q ^ bitIn;
        state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (!bitIn) ferr_d = 1'b1;
        state_d = ST_STOP2;
      end
      ST_STOP2: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_ARM;
    endcase

    // Hand-off to the holding register. The stop2 sample is folded in
    // directly because it is only seen on the completion edge.
    if (done) begin
      if (!dv_q || ack) begin
        data_d = shift_q;
        perr_d = (par_q != PARITY_ODD);
        fe_d   = ferr_q | ~bitIn;
        dv_d   = 1'b1;
        if (dv_q) ovr_d = 1'b0;  // ack on the completion edge also clears overrun
      end else begin
        ovr_d = 1'b1;
      end
    end else if (ack && dv_q) begin
      dv_d  = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARM;
      idx_q   <= 3'd0;
      par_q   <= 1'b0;
      shift_q <= 8'h00;
      ferr_q  <= 1'b0;
      data_q  <= 8'h00;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      perr_q  <= perr_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dataOut     = data_q;
  assign dataValid   = dv_q;
  assign parityError = perr_q;
  assign frameError  = fe_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != ST_ARM) && (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Purpose: self-checking bench for uart_receiver, even- and odd-parity instances side by side.
// Latency: inputs change 1 ns after posedge; outputs compared at the same point against a frame-level model.
// Backpressure: ack driven from tables, directed sequences and random draws.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset, bitIn, ack;
  logic [7:0] dout_e, dout_o;
  logic       dv_e, pe_e, fe_e, ov_e, busy_e;
  logic       dv_o, pe_o, fe_o, ov_o, busy_o;

  always #5 clk = ~clk;

  uart_receiver #(.PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .bitIn(bitIn), .ack(ack),
    .dataOut(dout_e), .dataValid(dv_e), .parityError(pe_e),
    .frameError(fe_e), .overrun(ov_e), .busy(busy_e)
  );

  uart_receiver #(.PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .bitIn(bitIn), .ack(ack),
    .dataOut(dout_o), .dataValid(dv_o), .parityError(pe_o),
    .frameError(fe_o), .overrun(ov_o), .busy(busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Frame-level reference: armed flag, a bit queue collecting the 11 bits
  // after a start bit, and the holding register contents.
  bit         m_armed, m_in;
  bit         m_q[$];
  logic [7:0] m_data;
  logic       m_dv, m_pe_e, m_pe_o, m_fe, m_ovr;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_step(input logic b, input logic a, input logic r);
    bit         complete;
    logic [7:0] nd;
    int         ones;
    if (r) begin
      m_armed = 0; m_in = 0; m_q.delete();
      m_data = 8'h00; m_dv = 0; m_pe_e = 0; m_pe_o = 0; m_fe = 0; m_ovr = 0;
      return;
    end
    complete = 0;
    if (m_in) begin
      m_q.push_back(b);
      if (m_q.size() == 11) begin complete = 1; m_in = 0; end
    end else if (!m_armed) begin
      if (b) m_armed = 1;
    end else if (!b) begin
      m_in = 1;
      m_q.delete();
    end
    if (complete) begin
      nd = 8'h00;
      ones = 0;
      for (int i = 0; i < 8; i++) nd[i] = m_q[i];
      for (int i = 0; i < 9; i++) ones += int'(m_q[i]);
      if (!m_dv || a) begin
        if (m_dv) m_ovr = 0;
        m_data = nd;
        m_pe_e = (ones % 2) != 0;
        m_pe_o = (ones % 2) != 1;
        m_fe   = !(m_q[9] && m_q[10]);
        m_dv   = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (a && m_dv) begin
      m_dv = 0;
      m_ovr = 0;
    end
  endtask

  task automatic tick(input logic b, input logic a, input logic r);
    bitIn = b; ack = a; reset = r;
    @(posedge clk);
    #1;
    m_step(b, a, r);
    check("cycle_even", {dout_e, dv_e, pe_e, fe_e, ov_e, busy_e},
          {m_data, m_dv, m_pe_e, m_fe, m_ovr, m_in});
    check("cycle_odd", {dout_o, dv_o, pe_o, fe_o, ov_o, busy_o},
          {m_data, m_dv, m_pe_o, m_fe, m_ovr, m_in});
  endtask

  function automatic logic [11:0] mk(input logic [7:0] d, input logic par,
                                     input logic s1, input logic s2);
    return {s2, s1, par, d, 1'b0};
  endfunction

  // Sends a whole frame; ack is asserted on the completion (last) bit only if ack_last.
  task automatic send(input logic [11:0] f, input logic ack_last);
    for (int i = 0; i < 12; i++) tick(f[i], (i == 11) ? ack_last : 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par, s1, s2;
    logic       exp_pe_e, exp_pe_o, exp_fe;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [11:0] f;
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; bitIn = 1'b0; ack = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("reset_even", {dout_e, dv_e, pe_e, fe_e, ov_e, busy_e}, 13'h0);
    check("reset_odd",  {dout_o, dv_o, pe_o, fe_o, ov_o, busy_o}, 13'h0);

    // Table: each frame from idle, with the previous one acknowledged first.
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      f = mk(tbl[i].d, tbl[i].par, tbl[i].s1, tbl[i].s2);
      for (int k = 0; k < 12; k++) begin
        tick(f[k], 1'b0, 1'b0);
        if (k == 10) check($sformatf("tbl%0d_dv_before_e11", i), {12'h0, dv_e}, 13'h0);
        if (k == 1)  check($sformatf("tbl%0d_busy", i), {12'h0, busy_e}, 13'h1);
      end
      check($sformatf("tbl%0d_even", i), {dout_e, dv_e, pe_e, fe_e, ov_e},
            {tbl[i].d, 1'b1, tbl[i].exp_pe_e, tbl[i].exp_fe, 1'b0});
      check($sformatf("tbl%0d_odd", i), {dout_o, dv_o, pe_o, fe_o, ov_o},
            {tbl[i].d, 1'b1, tbl[i].exp_pe_o, tbl[i].exp_fe, 1'b0});
    end

    // Back-to-back frames with no ack: second is dropped, overrun set.
    tick(1'b1, 1'b1, 1'b0);
    send(mk(8'h01, 1'b1, 1'b1, 1'b1), 1'b0);
    send(mk(8'h02, 1'b1, 1'b1, 1'b1), 1'b0);
    check("overrun_held", {3'b0, dout_e, dv_e, ov_e}, {3'b0, 8'h01, 1'b1, 1'b1});
    tick(1'b1, 1'b1, 1'b0);
    check("overrun_ack", {3'b0, dout_e, dv_e, ov_e}, {3'b0, 8'h01, 1'b0, 1'b0});

    // Ack on the completion edge of the second frame: new frame replaces the old.
    send(mk(8'h01, 1'b1, 1'b1, 1'b1), 1'b0);
    send(mk(8'h02, 1'b1, 1'b1, 1'b1), 1'b1);
    check("ack_on_complete", {3'b0, dout_e, dv_e, ov_e}, {3'b0, 8'h02, 1'b1, 1'b0});
    tick(1'b1, 1'b1, 1'b0);

    // Reset during d4 with the line held low: no frame until a 1 is seen.
    f = mk(8'hFF, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) tick(f[k], 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 1'b0);
    check("rst_midframe", {11'h0, dv_e, busy_e}, 13'h0);
    tick(1'b1, 1'b0, 1'b0);
    send(mk(8'hFF, 1'b0, 1'b1, 1'b1), 1'b0);
    check("after_rearm", {1'b0, dout_e, dv_e, pe_e, fe_e, ov_e}, {1'b0, 8'hFF, 4'b1000});
    tick(1'b1, 1'b1, 1'b0);

    // Random frames, gaps, acks and occasional resets against the model.
    for (int n = 0; n < 250; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        tick(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0), 1'b0);
      f = mk(8'($urandom), 1'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0));
      for (int k = 0; k < 12; k++)
        tick(f[k], ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter PARITY_ODD, default 0; 0 = even parity (data plus parity bit carry an even count of ones), 1 = odd parity.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 bitIn  input  1  serial line; idle high; one bit per clk cycle; already synchronous to clk.
REQ-005 ack  input  1  consumer accepts the held frame; effective only while dataValid=1.
REQ-006 dataOut  output  8  last accepted data byte.
REQ-007 dataValid  output  1  held frame available; level signal until acknowledged.
REQ-008 parityError  output  1  parity check failed for the held frame.
REQ-009 frameError  output  1  at least one stop bit of the held frame was 0.
REQ-010 overrun  output  1  sticky; a completed frame was discarded because the held frame was not yet acknowledged.
REQ-011 busy  output  1  high in any state other than IDLE and ARM.

Function
REQ-012 Frame format, one bit per cycle, LSB first: start(0), d0..d7, parity, stop1(1), stop2(1).
REQ-013 Every bitIn sample is taken at posedge clk; there is no oversampling and no baud divider.
REQ-014 States are ARM, IDLE, DATA, PARITY, STOP1 and STOP2; a 3-bit index counts d0..d7.
REQ-015 ARM -> IDLE on the first cycle bitIn=1; stay in ARM while bitIn=0.
REQ-016 IDLE -> DATA when bitIn=0 is sampled (start bit); clear the index and the running parity.
REQ-017 DATA: shift bitIn into bit[index] and XOR it into the running parity; -> PARITY after index 7 is sampled.
REQ-018 PARITY: XOR bitIn into the running parity; -> STOP1.
REQ-019 Parity error = (running parity incl. parity bit) != PARITY_ODD.
REQ-020 STOP1: record a frame error if bitIn=0; -> STOP2.
REQ-021 STOP2: record a frame error if bitIn=0; complete the frame; -> IDLE.
REQ-022 A frame received with parityError or frameError is still delivered, with its error flags set.
REQ-023 Completion with dataValid=0, or with dataValid=1 and ack=1: on the same edge load dataOut, parityError and frameError, and set dataValid=1.
REQ-024 Completion with dataValid=1 and ack=0: keep the held frame unchanged, set overrun=1, discard the new frame.
REQ-025 ack=1 with dataValid=1 and no completion: clear dataValid and overrun on that edge; dataOut and the error flags hold their values.
REQ-026 ack while dataValid=0 has no effect.
REQ-027 Latency: if the start bit is sampled at edge E0, dataValid is high in the cycle after edge E11.
REQ-028 Back-to-back frames: a start bit sampled at the edge immediately following STOP2 is accepted; no idle gap is required.
REQ-029 busy is combinational from state only.

Reset
REQ-030 reset=1: state=ARM, index=0, running parity=0, dataOut=8'h00, dataValid=0, parityError=0, frameError=0, overrun=0, busy=0.
REQ-031 reset takes priority over all other inputs; asserting it mid-frame discards the partial frame.
REQ-032 After reset, a start bit is recognised only after at least one bitIn=1 has been sampled (via ARM).

Verification
REQ-033 Reset, idle, then 0,1,0,1,0,0,1,0,1,0,1,1 -> dataOut=8'hA5, dataValid=1 after edge E11, parityError=0, frameError=0.
REQ-034 Same stream with parity bit 1 -> dataOut=8'hA5, parityError=1; with PARITY_ODD=1 and parity 1 -> parityError=0.
REQ-035 8'h3C frame with stop1=0 -> dataValid=1, frameError=1, dataOut=8'h3C.
REQ-036 Two back-to-back frames 8'h01 then 8'h02, no ack -> dataOut=8'h01, overrun=1; ack -> dataValid=0, overrun=0.
REQ-037 ack asserted on the completion edge of 8'h02 while 8'h01 is held -> dataOut=8'h02, dataValid stays 1, overrun=0.
REQ-038 reset pulsed during d4 with bitIn held 0 -> no dataValid; next valid frame 8'hFF received only after bitIn=1 is seen.
